ov7670_pixel_capture: RTL

Camera-side capture stage for the OV7670 video path: oversamples the sensor's PCLK/VSYNC/HREF/D[7:0] bus in the `clk` domain and assembles byte pairs into RGB565 pixels. It applies optional 2:1 horizontal and vertical decimation (640x480 → 320x240) and emits linear frame-buffer writes (`we_out`/`wAddr_out`/`wData_out`). These outputs feed the sharpening stage's `we_in`/`wAddr_in`/`wData_in` directly. Every frame starts at address 0 and per-frame completion/error status is reported.

---
 rtl/ov7670_pixel_capture.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture: oversampled camera bus to RGB565 frame-buffer writes.
// Ports: clk/reset; cam_pclk/vsync/href/data (async sensor bus);
//   capture_en (level, allow new frames); we_out/wAddr_out/wData_out
//   (one write per kept pixel); busy (frame active); frame_done/
//   frame_err (end-of-frame pulses); frame_cnt (count of good frames).
module ov7670_pixel_capture #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter bit DECIM_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic        we_out,
    output logic [16:0] wAddr_out,
    output logic [15:0] wData_out,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam int SRC_W = DECIM_EN ? 2 * IMG_WIDTH : IMG_WIDTH;
    localparam int SRC_H = DECIM_EN ? 2 * IMG_HEIGHT : IMG_HEIGHT;
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;

    localparam logic [10:0] SRC_W_L   = 11'(SRC_W);
    localparam logic [9:0]  SRC_H_L   = 10'(SRC_H);
    localparam logic [16:0] TOTAL_L   = 17'(TOTAL);
    localparam logic [16:0] LAST_ADDR = 17'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_ACTIVE,
        S_END
    } state_t;

    state_t state_q;
    state_t state_d;

    // Index 0/1 form the synchronizer, index 2 is the edge-detect copy.
    logic [2:0] pclk_sync;
    logic [2:0] vsync_sync;
    logic [2:0] href_sync;
    logic [7:0] data_s1;
    logic [7:0] data_s2;

    logic strobe;
    logic href_s2;
    logic vsync_rise;
    logic vsync_fall;
    logic href_rise;
    logic href_fall;

    logic        phase;
    logic [7:0]  hi_byte;
    logic [9:0]  src_col;
    logic [8:0]  src_row;
    logic [16:0] addr;
    logic [16:0] pix_cnt;

    logic       start_frame;
    logic       byte_take;
    logic       phase_eff;
    logic [9:0] col_eff;
    logic       keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            data_s1    <= '0;
            data_s2    <= '0;
        end else begin
            pclk_sync  <= {pclk_sync[1:0], cam_pclk};
            vsync_sync <= {vsync_sync[1:0], cam_vsync};
            href_sync  <= {href_sync[1:0], cam_href};
            data_s1    <= cam_data;
            data_s2    <= data_s1;
        end
    end

    assign strobe     = pclk_sync[1] & ~pclk_sync[2];
    assign href_s2    = href_sync[1];
    assign vsync_rise = vsync_sync[1] & ~vsync_sync[2];
    assign vsync_fall = ~vsync_sync[1] & vsync_sync[2];
    assign href_rise  = href_sync[1] & ~href_sync[2];
    assign href_fall  = ~href_sync[1] & href_sync[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        byte_take   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (capture_en) begin
                    state_d = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                if (vsync_fall) begin
                    state_d     = S_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            S_ACTIVE: begin
                // Frame end beats a coincident byte strobe.
                if (vsync_rise) begin
                    state_d = S_END;
                end else begin
                    byte_take = strobe & href_s2;
                end
            end
            S_END: begin
                state_d = capture_en ? S_WAIT_VS : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A line start in the same cycle as a byte makes that byte the
    // first (high) byte of column 0.
    assign phase_eff = href_rise ? 1'b0 : phase;
    assign col_eff   = href_rise ? '0 : src_col;

    assign keep = ({1'b0, col_eff} < SRC_W_L)
                & ({1'b0, src_row} < SRC_H_L)
                & (!DECIM_EN | (~col_eff[0] & ~src_row[0]));

    assign busy = (state_q == S_ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= 1'b0;
            hi_byte    <= '0;
            src_col    <= '0;
            src_row    <= '0;
            addr       <= '0;
            pix_cnt    <= '0;
            we_out     <= 1'b0;
            wAddr_out  <= '0;
            wData_out  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            we_out     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (start_frame) begin
                phase   <= 1'b0;
                src_col <= '0;
                src_row <= '0;
                addr    <= '0;
                pix_cnt <= '0;
            end else if (state_q == S_ACTIVE) begin
                if (href_rise) begin
                    phase   <= 1'b0;
                    src_col <= '0;
                end
                if (href_fall && src_col != '0 && src_row != '1) begin
                    src_row <= src_row + 9'd1;
                end
                if (byte_take) begin
                    if (!phase_eff) begin
                        hi_byte <= data_s2;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (col_eff != '1) begin
                            src_col <= col_eff + 10'd1;
                        end else begin
                            src_col <= col_eff;
                        end
                        if (keep) begin
                            we_out    <= 1'b1;
                            wAddr_out <= addr;
                            wData_out <= {hi_byte, data_s2};
                            if (addr != LAST_ADDR) begin
                                addr <= addr + 17'd1;
                            end
                            if (pix_cnt != '1) begin
                                pix_cnt <= pix_cnt + 17'd1;
                            end
                        end
                    end
                end
            end

            if (state_q == S_END) begin
                if (pix_cnt == TOTAL_L) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
